// File: rtl/call_scheduler.sv
//------------------------------------------------------------------------------
// call_scheduler : SCAN elevator call scheduler (IDLE/MOVE/STOP) with alarm hold.
// Optional macro SCHED_DWELL_RESTART_EN: same-floor call in STOP restarts dwell.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module call_scheduler #(
    parameter int N_FLOORS   = 4,
    parameter int DOOR_TICKS = 8,
    parameter int MOVE_TICKS = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        alarm,
    input  logic [N_FLOORS-1:0]         call_req,
    output logic                        door,
    output logic                        motor_up,
    output logic                        motor_down,
    output logic [$clog2(N_FLOORS)-1:0] floor,
    output logic [N_FLOORS-1:0]         pending
);

    localparam int FW   = $clog2(N_FLOORS);
    localparam int MAXT = (DOOR_TICKS > MOVE_TICKS) ? DOOR_TICKS : MOVE_TICKS;
    localparam int CW   = (MAXT > 1) ? $clog2(MAXT) : 1;
    localparam logic [FW-1:0] C_TOP       = FW'(N_FLOORS - 1);
    localparam logic [CW-1:0] C_MOVE_LOAD = CW'(MOVE_TICKS - 1);
    localparam logic [CW-1:0] C_DOOR_LOAD = CW'(DOOR_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MOVE = 2'd1,
        S_STOP = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_dir;
    logic [CW-1:0]   r_cnt;

    logic [N_FLOORS-1:0] w_here_mask;
    logic [N_FLOORS-1:0] w_arr_mask;
    logic [N_FLOORS-1:0] w_req_eff;
    logic [N_FLOORS-1:0] w_pend_nx;
    logic [FW-1:0]       w_step_floor;
    logic                w_can_step;
    logic                w_arr_hit;
    logic                w_dir_here;
    logic                w_dir_step;
    logic                w_restart;

    // Keep direction while a call lies beyond f in that direction, else reverse.
    function automatic logic scan_dir(input logic [N_FLOORS-1:0] p,
                                      input logic [FW-1:0] f,
                                      input logic d);
        logic above;
        logic below;
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (p[i] && (i > int'(f))) above = 1'b1;
            if (p[i] && (i < int'(f))) below = 1'b1;
        end
        return d ? above : ~below;
    endfunction

    always_comb begin
        w_here_mask        = '0;
        w_here_mask[floor] = 1'b1;
        w_req_eff    = (r_state == S_MOVE) ? call_req : (call_req & ~w_here_mask);
        w_pend_nx    = pending | w_req_eff;
        w_can_step   = r_dir ? (floor != C_TOP) : (floor != '0);
        w_step_floor = r_dir ? (floor + 1'b1) : (floor - 1'b1);
        w_arr_mask   = '0;
        if (w_can_step) w_arr_mask[w_step_floor] = 1'b1;
        w_arr_hit    = (w_pend_nx & w_arr_mask) != '0;
        w_dir_here   = scan_dir(w_pend_nx, floor, r_dir);
        w_dir_step   = scan_dir(w_pend_nx, w_step_floor, r_dir);
    end

`ifdef SCHED_DWELL_RESTART_EN
    assign w_restart = call_req[floor];
`else
    assign w_restart = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            floor      <= '0;
            r_dir      <= 1'b1;
            pending    <= '0;
            r_cnt      <= '0;
            door       <= 1'b0;
            motor_up   <= 1'b0;
            motor_down <= 1'b0;
        end else begin
            pending <= w_pend_nx;
            case (r_state)
                S_IDLE: begin
                    if ((w_pend_nx != '0) && !alarm) begin
                        r_state    <= S_MOVE;
                        r_dir      <= w_dir_here;
                        r_cnt      <= C_MOVE_LOAD;
                        door       <= 1'b1;
                        motor_up   <= w_dir_here;
                        motor_down <= ~w_dir_here;
                    end
                end
                S_MOVE: begin
                    if (alarm) begin
                        motor_up   <= 1'b0;
                        motor_down <= 1'b0;
                    end else if (r_cnt != '0) begin
                        r_cnt      <= r_cnt - 1'b1;
                        motor_up   <= r_dir;
                        motor_down <= ~r_dir;
                    end else if (w_arr_hit) begin
                        floor      <= w_step_floor;
                        pending    <= w_pend_nx & ~w_arr_mask;
                        r_state    <= S_STOP;
                        r_cnt      <= C_DOOR_LOAD;
                        door       <= 1'b0;
                        motor_up   <= 1'b0;
                        motor_down <= 1'b0;
                    end else if (w_can_step) begin
                        floor      <= w_step_floor;
                        r_dir      <= w_dir_step;
                        r_cnt      <= C_MOVE_LOAD;
                        motor_up   <= w_dir_step;
                        motor_down <= ~w_dir_step;
                    end else begin
                        // Unreachable while SCAN holds; turn around rather than pass a bound.
                        r_dir      <= ~r_dir;
                        r_cnt      <= C_MOVE_LOAD;
                        motor_up   <= ~r_dir;
                        motor_down <= r_dir;
                    end
                end
                S_STOP: begin
                    if (w_restart) begin
                        r_cnt <= C_DOOR_LOAD;
                    end else if (!alarm) begin
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - 1'b1;
                        end else if (w_pend_nx != '0) begin
                            r_state    <= S_MOVE;
                            r_dir      <= w_dir_here;
                            r_cnt      <= C_MOVE_LOAD;
                            door       <= 1'b1;
                            motor_up   <= w_dir_here;
                            motor_down <= ~w_dir_here;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
